// File: rtl/fpa_issue_arbiter.sv
// Round-robin issue arbiter that shares one fixed-latency pipelined FP adder
// among NREQ requesters and routes each sum back to its requester via a tag pipe.
module fpa_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int LAT   = 4,
  parameter int TAGW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      fpa_a,
  output logic [WIDTH-1:0]      fpa_b,
  input  logic [WIDTH-1:0]      fpa_result,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  busy
);

  logic [TAGW-1:0] ptr;
  logic [NREQ-1:0] hi_req;
  logic [TAGW-1:0] gidx;
  logic            grant_any;

  logic [LAT:0]    pipe_vld;
  logic [TAGW-1:0] pipe_tag [LAT+1];

  // Requests at or above the pointer win; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_req = '0;
    gidx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_req[i] = req_valid[i] && (i >= int'(ptr));
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) gidx = TAGW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi_req[i]) gidx = TAGW'(i);
    end
    grant_any = |req_valid;
    req_ready = grant_any ? (NREQ'(1) << gidx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      fpa_a    <= '0;
      fpa_b    <= '0;
      pipe_vld <= '0;
    end else begin
      pipe_vld <= {pipe_vld[LAT-1:0], grant_any};
      if (grant_any) begin
        fpa_a <= req_a[int'(gidx)*WIDTH +: WIDTH];
        fpa_b <= req_b[int'(gidx)*WIDTH +: WIDTH];
        ptr   <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
      end else begin
        fpa_a <= '0;
        fpa_b <= '0;
      end
    end
  end

  // NOTE: tag storage has no reset; a tag is only ever read alongside its
  // valid bit, which is reset, so clearing the tags would buy nothing.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= gidx;
    for (int k = 1; k <= LAT; k++) begin
      pipe_tag[k] <= pipe_tag[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (pipe_vld[LAT]) begin
      resp_valid <= NREQ'(1) << pipe_tag[LAT];
      resp_data  <= fpa_result;
    end else begin
      resp_valid <= '0;
    end
  end

  assign busy = (|pipe_vld) || (|resp_valid);

endmodule

// File: doc/fpa_issue_arbiter.md
Name: fpa_issue_arbiter

Overview:
- Shares one pipelined 64-bit floating-point adder (pipeFPA32) between NREQ requesters.
- Each cycle, a round-robin arbiter grants one valid request and registers its operands into the adder.
- A tag/valid shift register runs in lockstep with the adder pipeline. It routes each sum back to its originating requester.
- Sits between the requesting units and the adder instance. The adder's own ready output is not used; the block assumes a fixed latency of LAT.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/result width in bits.
- LAT, 4, clock cycles from adder operand inputs (fpa_a/fpa_b) to the matching value on fpa_result.
- TAGW, 2, tag width; must equal ceil(log2(NREQ)), minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a
- req_ready  out  NREQ  one-hot grant; request i is accepted in a cycle where req_valid[i] & req_ready[i]
- fpa_a  out  WIDTH  registered operand to the adder's number1
- fpa_b  out  WIDTH  registered operand to the adder's number2
- fpa_result  in  WIDTH  adder result
- resp_valid  out  NREQ  one-hot, single-cycle result strobe
- resp_data  out  WIDTH  result; valid only while resp_valid != 0
- busy  out  1  high while any accepted operation has not yet produced resp_valid

Behaviour:
- Reset (rst=0, asynchronous): the following are cleared:
  - round-robin pointer = 0
  - fpa_a = fpa_b = 0
  - tag pipe valid bits = 0
  - resp_valid = 0, resp_data = 0
  - busy = 0
- req_ready is combinational. It is at most one-hot, and req_ready[i] is 1 only if req_valid[i] = 1.
- Priority search starts at the pointer and wraps modulo NREQ. The first index with req_valid set is granted.
- No backpressure from the adder: if any req_valid is high, exactly one grant occurs that cycle.
- Pointer update on a grant to g: pointer <= (g+1) mod NREQ. With no grant, the pointer holds.
- On the edge ending an accept cycle (edge E):
  - fpa_a <= req_a[g], fpa_b <= req_b[g]
  - tag pipe stage 0 <= {valid=1, tag=g}
- With no accept on edge E: fpa_a/fpa_b <= 0 and stage 0 valid <= 0.
- Tag pipe has LAT+1 stages and shifts every cycle. It is never stalled.
- When the final stage is valid at an edge: resp_data <= fpa_result and resp_valid <= one-hot(tag). Otherwise resp_valid <= 0 and resp_data holds.
- Latency: an accept at edge E produces resp_valid high for exactly the one cycle following edge E+LAT+1.
- Throughput: one operation per cycle. Back-to-back accepts give back-to-back resp_valid strobes, in acceptance order.
- The same requester may be granted on consecutive cycles only when no other requester is valid.
- busy = OR of all tag pipe valid bits plus the resp-stage valid. Combinationally registered state only; no dependence on req_valid.
- req_a/req_b are sampled only in accept cycles. Requesters may change operands after acceptance.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid is produced for them. After rst deasserts, the first resp_valid needs a fresh accept.
- If req_valid drops without acceptance, the request is withdrawn; there is no stored state.

Test Plan:
- Single request, NREQ=4, LAT=4: requester 1 presents 0x4056800000000000 + 0x4056800000000000 (90+90) for one cycle.
  -> req_ready=0010 that cycle.
  -> resp_valid=0010 exactly LAT+1 edges after accept, with resp_data=0x4066800000000000 (180).
  -> busy is high from the accept edge through the resp cycle.
- All four requesters valid continuously, each with 0x4049000000000000 + 0x4034000000000000 (50+20).
  -> grants rotate 0,1,2,3,0...
  -> resp_valid rotates in the same order, one per cycle, every resp_data=0x4051800000000000 (70).
- Pointer at 2 with only requesters 0 and 3 valid.
  -> grant 3, then 0, then 3.
  -> responses arrive in the same order.
- Interleaved sums: requester 0 sends 90+90 and requester 2 sends 50+20 on alternating cycles.
  -> each strobe carries the correct sum (180 to requester 0, 70 to requester 2).
  -> no strobe lands on the wrong requester.
- rst pulled low 2 cycles after three accepts.
  -> all outputs are 0 immediately, without waiting for a clock edge.
  -> no resp_valid appears after release.
  -> a new request after release returns its result with normal latency.
- Idle cycles between requests.
  -> fpa_a = fpa_b = 0 and resp_valid = 0 throughout.
  -> busy falls the cycle after the last resp_valid.
